// File: rtl/input_vc_buffer_pkg.sv
// Shared router types: flit encoding, per-VC control states, and head/tail classification.
package input_vc_buffer_pkg;

    typedef enum logic [1:0] {
        FLIT_HEADER = 2'd0,
        FLIT_BODY   = 2'd1,
        FLIT_TAIL   = 2'd2,
        FLIT_HT     = 2'd3
    } flit_type_t;

    typedef enum logic [1:0] {
        VC_IDLE    = 2'd0,
        VC_WAIT_VA = 2'd1,
        VC_ACTIVE  = 2'd2
    } vc_state_t;

    localparam int FLIT_TYPE_W = $bits(flit_type_t);

    function automatic logic is_head(input flit_type_t t);
        return (t == FLIT_HEADER) || (t == FLIT_HT);
    endfunction

    function automatic logic is_tail(input flit_type_t t);
        return (t == FLIT_TAIL) || (t == FLIT_HT);
    endfunction

endpackage

// File: rtl/input_vc_buffer_fifo.sv
// Synchronous first-word-fallthrough FIFO for one virtual channel, exposing next-cycle occupancy.
module vc_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 66
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [W-1:0]               wr_data,
    input  logic                       rd_en,
    output logic [W-1:0]               rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count_nxt,
    output logic                       empty,
    output logic                       wr_ok
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full, push, pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign pop   = rd_en && !empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign push  = wr_en && (!full || pop);
    assign wr_ok = push;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data   = empty ? '0 : mem_q[rd_ptr_q];
    assign count_nxt = count_d;

endmodule

// File: rtl/input_vc_buffer.sv
// Router input port: one FWFT FIFO per virtual channel plus a per-VC IDLE/WAIT_VA/ACTIVE
// controller that requests VC and switch allocation and reports on/off backpressure.
module input_vc_buffer
    import input_vc_buffer_pkg::*;
#(
    parameter int M         = 4,
    parameter int DEPTH     = 8,
    parameter int FLIT_W    = 64,
    parameter int ON_OFF_TH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [$clog2(M)-1:0]       wr_vc,
    input  logic [FLIT_W-1:0]          wr_flit,
    input  flit_type_t                 wr_type,
    input  logic [M-1:0]               va_grant,
    input  logic [M-1:0]               sa_grant,
    output logic [M-1:0]               va_req,
    output logic [M-1:0]               sa_req,
    output logic [M-1:0][FLIT_W-1:0]   head_flit,
    output flit_type_t [M-1:0]         head_type,
    output logic [M-1:0]               on_off,
    output logic [1:0]                 err
);

    localparam int VC_W  = $clog2(M);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = FLIT_W + FLIT_TYPE_W;
    localparam logic [CNT_W-1:0] STOP_LVL = CNT_W'(DEPTH - ON_OFF_TH);

    vc_state_t              state_q [M];
    vc_state_t              state_d [M];
    logic [M-1:0]           on_off_q, on_off_d;
    logic [1:0]             err_q, err_d;

    logic [M-1:0]           push_req, accepted, pop, empty, proto_err;
    logic [M-1:0][CNT_W-1:0] cnt_nxt;

    for (genvar v = 0; v < M; v++) begin : g_vc
        logic [ENT_W-1:0] rd_data;

        assign push_req[v] = wr_en && (wr_vc == VC_W'(v));

        vc_fifo #(
            .DEPTH (DEPTH),
            .W     (ENT_W)
        ) u_fifo (
            .clk       (clk),
            .rst       (reset),
            .wr_en     (push_req[v]),
            .wr_data   ({wr_type, wr_flit}),
            .rd_en     (pop[v]),
            .rd_data   (rd_data),
            .count_nxt (cnt_nxt[v]),
            .empty     (empty[v]),
            .wr_ok     (accepted[v])
        );

        assign head_flit[v] = rd_data[FLIT_W-1:0];
        assign head_type[v] = flit_type_t'(rd_data[ENT_W-1:FLIT_W]);
        assign on_off_d[v]  = (cnt_nxt[v] >= STOP_LVL);
        assign va_req[v]    = (state_q[v] == VC_WAIT_VA);
        assign sa_req[v]    = (state_q[v] == VC_ACTIVE) && !empty[v];
    end

    // Pops happen only for a granted active VC, or to discard a stray non-header in IDLE.
    always_comb begin
        pop       = '0;
        proto_err = '0;
        for (int v = 0; v < M; v++) begin
            state_d[v] = state_q[v];
            case (state_q[v])
                VC_IDLE: begin
                    if (!empty[v]) begin
                        if (is_head(head_type[v])) begin
                            state_d[v] = VC_WAIT_VA;
                        end else begin
                            proto_err[v] = 1'b1;
                            pop[v]       = 1'b1;
                        end
                    end
                end
                VC_WAIT_VA: begin
                    if (va_grant[v]) state_d[v] = VC_ACTIVE;
                end
                VC_ACTIVE: begin
                    if (sa_grant[v] && !empty[v]) begin
                        pop[v] = 1'b1;
                        if (is_tail(head_type[v])) state_d[v] = VC_IDLE;
                    end
                end
                default: state_d[v] = VC_IDLE;
            endcase
        end
    end

    always_comb begin
        err_d    = err_q;
        err_d[0] = err_q[0] | (|(push_req & ~accepted));
        err_d[1] = err_q[1] | (|proto_err);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int v = 0; v < M; v++) state_q[v] <= VC_IDLE;
            on_off_q <= '0;
            err_q    <= '0;
        end else begin
            for (int v = 0; v < M; v++) state_q[v] <= state_d[v];
            on_off_q <= on_off_d;
            err_q    <= err_d;
        end
    end

    assign on_off = on_off_q;
    assign err    = err_q;

endmodule

// File: tb/tb_input_vc_buffer.sv
// Randomized and directed bench for input_vc_buffer against a queue-based packet model.
module tb_input_vc_buffer;
    import input_vc_buffer_pkg::*;

    localparam int M      = 4;
    localparam int DEPTH  = 8;
    localparam int FLIT_W = 64;
    localparam int TH     = 2;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     wr_en;
    logic [1:0]               wr_vc;
    logic [FLIT_W-1:0]        wr_flit;
    flit_type_t               wr_type;
    logic [M-1:0]             va_grant, sa_grant;
    logic [M-1:0]             va_req, sa_req, on_off;
    logic [M-1:0][FLIT_W-1:0] head_flit;
    flit_type_t [M-1:0]       head_type;
    logic [1:0]               err;

    always #5 clk = ~clk;

    input_vc_buffer #(.M(M), .DEPTH(DEPTH), .FLIT_W(FLIT_W), .ON_OFF_TH(TH)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_vc(wr_vc), .wr_flit(wr_flit),
        .wr_type(wr_type), .va_grant(va_grant), .sa_grant(sa_grant), .va_req(va_req),
        .sa_req(sa_req), .head_flit(head_flit), .head_type(head_type), .on_off(on_off),
        .err(err)
    );

    typedef struct packed { flit_type_t t; logic [FLIT_W-1:0] d; } mflit_t;

    mflit_t       q [M][$];
    int           phase [M];   // 0 no packet, 1 awaiting VC grant, 2 forwarding
    logic [1:0]   m_err;
    logic [M-1:0] m_on_off;
    int           n_chk = 0;
    int           n_err = 0;
    bit           in_pkt [M];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int v = 0; v < M; v++) begin
            q[v].delete();
            phase[v] = 0;
        end
        m_err    = '0;
        m_on_off = '0;
    endfunction

    function automatic void model_step();
        for (int v = 0; v < M; v++) begin
            bit     popped;
            mflit_t h;
            mflit_t nf;
            popped = 0;
            h      = '0;
            if (q[v].size() > 0) h = q[v][0];
            case (phase[v])
                0: if (q[v].size() > 0) begin
                    if (h.t == FLIT_HEADER || h.t == FLIT_HT) phase[v] = 1;
                    else begin m_err[1] = 1'b1; popped = 1; end
                end
                1: if (va_grant[v]) phase[v] = 2;
                default: if (sa_grant[v] && q[v].size() > 0) begin
                    popped = 1;
                    if (h.t == FLIT_TAIL || h.t == FLIT_HT) phase[v] = 0;
                end
            endcase
            if (popped) void'(q[v].pop_front());
            if (wr_en && int'(wr_vc) == v) begin
                if (q[v].size() < DEPTH) begin
                    nf.t = wr_type;
                    nf.d = wr_flit;
                    q[v].push_back(nf);
                end else begin
                    m_err[0] = 1'b1;
                end
            end
            m_on_off[v] = (q[v].size() >= DEPTH - TH);
        end
    endfunction

    task automatic compare_all(input string tag);
        for (int v = 0; v < M; v++) begin
            logic [63:0] et, ed;
            et = 64'(FLIT_HEADER);
            ed = '0;
            if (q[v].size() > 0) begin
                et = 64'(q[v][0].t);
                ed = q[v][0].d;
            end
            chk($sformatf("%s va_req[%0d]", tag, v), 64'(va_req[v]), 64'(phase[v] == 1));
            chk($sformatf("%s sa_req[%0d]", tag, v), 64'(sa_req[v]),
                64'(phase[v] == 2 && q[v].size() > 0));
            chk($sformatf("%s on_off[%0d]", tag, v), 64'(on_off[v]), 64'(m_on_off[v]));
            chk($sformatf("%s head_type[%0d]", tag, v), 64'(head_type[v]), et);
            chk($sformatf("%s head_flit[%0d]", tag, v), head_flit[v], ed);
        end
        chk($sformatf("%s err", tag), 64'(err), 64'(m_err));
    endtask

    task automatic set_idle();
        wr_en    = 1'b0;
        wr_vc    = '0;
        wr_flit  = '0;
        wr_type  = FLIT_HEADER;
        va_grant = '0;
        sa_grant = '0;
    endtask

    task automatic put(input int vc, input flit_type_t t);
        wr_en   = 1'b1;
        wr_vc   = 2'(vc);
        wr_type = t;
        wr_flit = {$urandom, $urandom};
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all(tag);
        set_idle();
    endtask

    task automatic do_reset(input string tag);
        set_idle();
        reset = 1'b1;
        #1;
        chk({tag, " rst va_req"}, 64'(va_req), 64'd0);
        chk({tag, " rst sa_req"}, 64'(sa_req), 64'd0);
        chk({tag, " rst on_off"}, 64'(on_off), 64'd0);
        chk({tag, " rst err"}, 64'(err), 64'd0);
        chk({tag, " rst head_flit"}, 64'(|head_flit), 64'd0);
        chk({tag, " rst head_type"}, 64'(head_type), 64'd0);
        model_reset();
        for (int v = 0; v < M; v++) in_pkt[v] = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        compare_all({tag, " released"});
    endtask

    initial begin
        int cnt;
        bit sa_seen [12];
        bit va_seen [12];
        int i_drop, j_rise;

        set_idle();
        reset = 1'b1;
        @(negedge clk);
        do_reset("init");

        // Single packet on VC1, VC grant two cycles after the header, switch grant held
        sa_grant = 4'b0010; put(1, FLIT_HEADER); tick("p038_c0");
        sa_grant = 4'b0010; put(1, FLIT_BODY);   tick("p038_c1");
        chk("p038 va_req1 waiting", 64'(va_req[1]), 64'd1);
        sa_grant = 4'b0010; va_grant = 4'b0010; put(1, FLIT_TAIL); tick("p038_c2");
        cnt = int'(sa_req[1]);
        for (int k = 0; k < 5; k++) begin
            sa_grant = 4'b0010;
            tick("p038_drain");
            cnt += int'(sa_req[1]);
        end
        chk("p038 sa_req cycles", 64'(cnt), 64'd3);
        chk("p038 back idle va", 64'(va_req[1]), 64'd0);

        // On/off threshold on VC0
        do_reset("onoff");
        put(0, FLIT_HEADER); tick("onoff_w1");
        for (int k = 2; k <= 6; k++) begin
            put(0, FLIT_BODY);
            tick("onoff_w");
            if (k == 5) chk("onoff low at 5", 64'(on_off[0]), 64'd0);
        end
        chk("onoff high at 6", 64'(on_off[0]), 64'd1);
        va_grant = 4'b0001; tick("onoff_va");
        sa_grant = 4'b0001; tick("onoff_pop");
        chk("onoff falls after pop", 64'(on_off[0]), 64'd0);

        // Overflow on VC2, then full write with a simultaneous pop
        do_reset("ovf");
        put(2, FLIT_HEADER); tick("ovf_fill");
        for (int k = 0; k < 7; k++) begin put(2, FLIT_BODY); tick("ovf_fill"); end
        chk("ovf no err at 8", 64'(err[0]), 64'd0);
        put(2, FLIT_BODY); tick("ovf_drop");
        chk("ovf err0 set", 64'(err[0]), 64'd1);
        va_grant = 4'b0100; tick("ovf_va");
        put(2, FLIT_BODY); sa_grant = 4'b0100; tick("ovf_popwr");
        chk("ovf still full", 64'(on_off[2]), 64'd1);
        for (int k = 0; k < 9; k++) begin sa_grant = 4'b0100; tick("ovf_drain"); end

        // Stray BODY on empty VC3
        do_reset("proto");
        put(3, FLIT_BODY); tick("proto_w");
        tick("proto_disc");
        chk("proto err1", 64'(err[1]), 64'd1);
        chk("proto va_req3", 64'(va_req[3]), 64'd0);
        tick("proto_after");

        // Back-to-back packets on VC2: one IDLE cycle between sa_req fall and va_req rise
        do_reset("b2b");
        for (int k = 0; k < 12; k++) begin
            va_grant = 4'b0100;
            sa_grant = 4'b0100;
            case (k)
                0: put(2, FLIT_HEADER);
                1: put(2, FLIT_TAIL);
                2: put(2, FLIT_HEADER);
                3: put(2, FLIT_TAIL);
                default: ;
            endcase
            tick("b2b");
            sa_seen[k] = sa_req[2];
            va_seen[k] = va_req[2];
        end
        i_drop = -1;
        j_rise = -100;
        for (int k = 1; k < 12; k++)
            if (i_drop < 0 && sa_seen[k-1] && !sa_seen[k]) i_drop = k;
        for (int k = 11; k > 0; k--)
            if (i_drop >= 0 && k > i_drop && va_seen[k]) j_rise = k;
        chk("b2b idle gap", 64'(j_rise - i_drop), 64'd1);

        // Reset while VC1 is forwarding
        do_reset("mid");
        put(0, FLIT_HT); tick("mid_c0");
        put(1, FLIT_HEADER); tick("mid_c1");
        va_grant = 4'b0011; put(1, FLIT_BODY); tick("mid_c2");
        va_grant = 4'b0011; tick("mid_c3");
        chk("mid vc1 active", 64'(sa_req[1]), 64'd1);
        do_reset("mid");
        put(1, FLIT_HEADER); tick("mid_after_w");

        // Random traffic: balanced drain, then sparse switch grants to build backpressure
        do_reset("rand");
        for (int k = 0; k < 1400; k++) begin
            if ($urandom_range(0, 99) < 60) begin
                int v;
                flit_type_t t;
                v = $urandom_range(0, M - 1);
                if ($urandom_range(0, 19) == 0)  t = flit_type_t'($urandom_range(0, 3));
                else if (!in_pkt[v])             t = ($urandom_range(0, 2) == 0) ? FLIT_HT : FLIT_HEADER;
                else                             t = ($urandom_range(0, 2) == 0) ? FLIT_TAIL : FLIT_BODY;
                if (t == FLIT_HEADER) in_pkt[v] = 1;
                if (t == FLIT_TAIL || t == FLIT_HT) in_pkt[v] = 0;
                put(v, t);
            end
            va_grant = 4'($urandom);
            if (k < 700) sa_grant = 4'($urandom);
            else         sa_grant = 4'($urandom) & 4'($urandom) & 4'($urandom);
            tick("rand");
            if (k == 900) do_reset("rand_mid");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
